// File: rtl/pc_gen_stage_pkg.sv
// Shared CPU constants: boot/exception vectors (also used by CP0) and the
// PC-generation state encoding.
package pc_gen_stage_pkg;

    localparam logic [31:0] RESET_ADDR = 32'hbfc00000;
    localparam logic [31:0] EXC_ADDR   = 32'hbfc00380;

    typedef enum logic [1:0] {
        StBoot = 2'd0,
        StRun  = 2'd1,
        StHold = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pc_sel_mux.sv
// Priority select of the next fetch PC: exception entry, ERET, branch
// redirect, then the fall-through (PC+4 or a buffered redirect).
module pc_sel_mux
    import pc_gen_stage_pkg::*;
(
    input  logic        exc_flush,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic [31:0] fallthrough,
    output logic [31:0] npc
);

    always_comb begin
        npc = fallthrough;
        if (exc_flush) begin
            npc = EXC_ADDR;
        end else if (eret) begin
            npc = epc;
        end else if (br_valid) begin
            npc = br_target;
        end
    end

endmodule

// File: rtl/pc_gen_stage.sv
// PC generation stage: holds the fetch PC, drives the instruction-SRAM address
// one cycle ahead of data, and buffers a branch redirect across stalls.
module pc_gen_stage
    import pc_gen_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        exc_flush,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] PC_next,
    output logic        IRWrite,
    output logic        PC_AdEL
);

    pc_state_e   state, state_d;
    logic [31:0] pc_r, pc_d;
    logic [31:0] pend_r, pend_d;
    logic [31:0] npc, fallthrough;
    logic        br_sel, trap;
    logic [31:0] addr_c;
    logic        irw_c;

    // Redirects from ID are ignored in BOOT; in HOLD the buffered target
    // replaces the sequential address.
    assign br_sel      = br_valid && (state != StBoot);
    assign fallthrough = (state == StHold) ? pend_r : pc_r + 32'd4;
    assign trap        = exc_flush || eret;

    pc_sel_mux u_pc_sel_mux (
        .exc_flush   (exc_flush),
        .eret        (eret),
        .epc         (epc),
        .br_valid    (br_sel),
        .br_target   (br_target),
        .fallthrough (fallthrough),
        .npc         (npc)
    );

    always_comb begin
        state_d = state;
        pc_d    = pc_r;
        pend_d  = pend_r;
        addr_c  = pc_r;
        irw_c   = 1'b0;
        unique case (state)
            StBoot: begin
                state_d = StRun;
                if (trap) begin
                    pc_d   = npc;
                    addr_c = npc;
                end
            end
            StRun, StHold: begin
                if (trap) begin
                    pc_d    = npc;
                    addr_c  = npc;
                    irw_c   = ~stall;
                    pend_d  = 32'd0;
                    state_d = StRun;
                end else if (stall) begin
                    // Re-read the current PC so returning data stays consistent.
                    if (br_valid) begin
                        pend_d  = br_target;
                        state_d = StHold;
                    end
                end else begin
                    pc_d    = npc;
                    addr_c  = npc;
                    irw_c   = 1'b1;
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StBoot;
                pc_d    = RESET_ADDR;
                pend_d  = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= StBoot;
            pc_r   <= RESET_ADDR;
            pend_r <= 32'd0;
        end else begin
            state  <= state_d;
            pc_r   <= pc_d;
            pend_r <= pend_d;
        end
    end

    assign inst_sram_addr = rst ? RESET_ADDR : addr_c;
    assign PC_next        = rst ? RESET_ADDR : pc_r;
    assign IRWrite        = rst ? 1'b0 : irw_c;
    assign PC_AdEL        = (PC_next[1:0] != 2'b00);

endmodule
